// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per transfer, MSB first, with optional ss hold for bursts.
// sclk half-period is DIV sys_clk cycles; miso is sampled on the sys_clk edge that ends each HIGH phase.
module spi_master #(
    parameter int DIV = 2
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] spi_data_in,
    input  logic       hold_ss,
    output logic [7:0] spi_data_out,
    output logic       data_rdy,
    output logic       busy,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic [2:0] state_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_HIGH     = 3'd2;
    localparam logic [2:0] S_LOW      = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;
    localparam logic [2:0] S_DESELECT = 3'd5;

    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] dout_q, dout_d;
    logic       rdy_q, rdy_d;
    logic       accept;

    // Handshake: start is taken on any edge where busy=0 (IDLE or GAP); spi_data_in is
    // captured on that same edge. While busy=1 start is dropped, never queued.
    assign accept = start && ((state_q == S_IDLE) || (state_q == S_GAP));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        rdy_d   = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_SETUP, S_LOW: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_HIGH;
                    cnt_d   = DIV_M1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HIGH: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    rx_d  = {rx_q[6:0], miso};
                    cnt_d = DIV_M1;
                    if (bit_q == 3'd7) begin
                        // tx_q is left unshifted so mosi keeps the last bit through GAP
                        dout_d  = {rx_q[6:0], miso};
                        rdy_d   = 1'b1;
                        state_d = hold_ss ? S_GAP : S_DESELECT;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = {tx_q[6:0], 1'b0};
                        state_d = S_LOW;
                    end
                end
            end
            S_GAP: begin
                if (!hold_ss) begin
                    state_d = S_DESELECT;
                    cnt_d   = DIV_M1;
                end
            end
            S_DESELECT: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A start in GAP overrides a simultaneous hold_ss drop
        if (accept) begin
            state_d = S_SETUP;
            cnt_d   = DIV_M1;
            bit_d   = 3'd0;
            tx_d    = spi_data_in;
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 3'd0;
            tx_q    <= 8'd0;
            rx_q    <= 8'd0;
            dout_q  <= 8'd0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            rdy_q   <= rdy_d;
        end
    end

    assign ss           = (state_q == S_IDLE) || (state_q == S_DESELECT);
    assign sclk         = (state_q == S_HIGH);
    assign busy         = !((state_q == S_IDLE) || (state_q == S_GAP));
    assign mosi         = ss ? 1'b0 : tx_q[7];
    assign spi_data_out = dout_q;
    assign data_rdy     = rdy_q;
    assign state_o      = state_q;

endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 master that drives the expander's serial port (ss, sclk, mosi, miso) from on-chip logic, one byte per transfer, MSB first. It is the initiator counterpart to the existing SPI slave: a host-side core issues bytes through a start/busy/data_rdy handshake and receives the byte shifted back on miso. Used on test chips and FPGA harnesses to exercise the expander, and for chip-to-chip links in later designs.

## Interface
Parameters:
- DIV, 2, sclk half-period in sys_clk cycles; legal range 1..255
- Ports (clock and reset first):
- sys_clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- start  input  1  request a transfer; sampled only when busy=0
- spi_data_in  input  8  byte to transmit; latched on the cycle start is accepted
- hold_ss  input  1  1 keeps ss low after the byte, for a multi-byte burst
- spi_data_out  output  8  last received byte; holds until the next byte completes
- data_rdy  output  1  one-cycle pulse when spi_data_out is updated
- busy  output  1  transfer or deselect gap in progress
- ss  output  1  slave select, active low
- sclk  output  1  serial clock, idle low (CPOL=0)
- mosi  output  1  serial data out
- miso  input  1  serial data in; sampled in the sys_clk domain, no synchronizer

## Operation
- States: IDLE, SETUP, HIGH, LOW, GAP, DESELECT.
- Reset (rst=0, immediate): state IDLE, ss=1, sclk=0, mosi=0, busy=0, data_rdy=0, spi_data_out=8'h00, shift registers and counters cleared. Reset mid-transfer aborts with no data_rdy.
- IDLE: ss=1, busy=0. start=1 -> latch spi_data_in, go SETUP.
- SETUP: ss=0, mosi=bit7, busy=1, sclk=0; lasts DIV cycles, then HIGH.
- HIGH: sclk=1 for DIV cycles. On the edge ending HIGH: sample miso into rx LSB (shift left), sclk=0, mosi advances to next bit. After bits 0..6 -> LOW; after bit 7 -> completion.
- LOW: sclk=0 for DIV cycles, then HIGH.
- Completion (edge ending 8th HIGH): spi_data_out <= received byte, data_rdy=1 for exactly one cycle. hold_ss=1 -> GAP; hold_ss=0 -> DESELECT with ss=1.
- GAP: ss=0, sclk=0, busy=0. start=1 -> latch byte, SETUP (ss stays low, no deselect). hold_ss=0 and no start -> DESELECT. start and hold_ss=0 in the same cycle: start wins.
- DESELECT: ss=1, busy=1 for DIV cycles (minimum ss-high time), then IDLE.
- start while busy=1 is ignored, not queued. spi_data_in changes after acceptance have no effect.
- mosi holds its last driven bit in GAP; forced to 0 in IDLE/DESELECT.

## Timing
- Start accepted at edge 0; ss falls and busy rises at edge 1.
- Bit i (0=MSB): sclk rises at edge 1+DIV+2*DIV*i, falls at edge 1+2*DIV+2*DIV*i.
- data_rdy and new spi_data_out at edge 1+16*DIV after start (DIV=2: edge 33); busy falls at same edge if hold_ss=1, else DIV cycles later.
- sclk period 2*DIV sys_clk cycles; duty 50%; first rising edge DIV cycles after ss falls.
- miso must be stable for the last sys_clk edge of each HIGH phase; slave's synchronizer delay must be < DIV cycles of sys_clk at matching clock rates.
- Back-to-back: in GAP, start at edge n gives next ss-held SETUP at edge n+1.

## Test plan
- Reset: hold rst=0, toggle start -> ss=1, sclk=0, mosi=0, busy=0, data_rdy=0, spi_data_out=8'h00.
- Single byte, DIV=2: send 8'hA5, loopback-model slave returns 8'h3C -> mosi bits 1,0,1,0,0,1,0,1 on sclk rising edges, exactly 8 sclk pulses, data_rdy one cycle at edge 33, spi_data_out=8'h3C, ss high after.
- Burst: hold_ss=1, bytes 8'h01, 8'h80, 8'hFF -> ss low throughout, three data_rdy pulses; with slave echoing prior byte, outputs 8'h00, 8'h01, 8'h80.
- Start while busy: assert start mid-transfer -> ignored, single data_rdy, byte unchanged; DESELECT keeps ss high DIV cycles before next start accepted.
- Reset mid-transfer after bit 3 -> immediate idle outputs, no data_rdy, next transfer of 8'h5A completes correctly.
- DIV=1 and DIV=7 -> sclk period 2 and 14 cycles, data_rdy at edges 17 and 113; against actual spi_slave instance, register write/readback through expander matches.
